fpu_bypass_ctrl: RTL

Operand-bypass and hazard controller for the FPU datapath; drives the 2-bit address inputs of the two 4:1 x32 operand-select muxes in front of the FP execute unit (fs and ft operands). Tracks destination registers of in-flight fixed-latency FP ops in a shift-register scoreboard. Selects regfile or forwarded result per operand and stalls issue on an unresolved RAW hazard. Also emits the regfile writeback strobe.

---
 rtl/fpu_bypass_ctrl_pkg.sv | 24 ++
 rtl/fpu_hazard_lookup.sv | 42 ++++
 rtl/fpu_bypass_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/fpu_bypass_ctrl_pkg.sv
// fpu_bypass_ctrl_pkg
// Shared definitions for the FPU operand-bypass controller:
//   - default execute latency and register-address width
//   - operand mux select encodings (regfile / result / result reg / writeback reg)
//   - the in-flight stage record carried down the bypass scoreboard
package fpu_bypass_ctrl_pkg;

  localparam int LAT_DEF = 3;
  localparam int AW_DEF  = 5;

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_RES  = 2'd1;
  localparam logic [1:0] SEL_RES1 = 2'd2;
  localparam logic [1:0] SEL_WB   = 2'd3;

  // One scoreboard slot. The fd field is sized by AW_DEF, so the controller's
  // AW parameter must stay equal to AW_DEF.
  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [AW_DEF-1:0] fd;
  } stage_t;

endpackage

// File: rtl/fpu_hazard_lookup.sv
// fpu_hazard_lookup
// Purely combinational per-operand lookup into the in-flight scoreboard.
// Ports:
//   stages - scoreboard stages S1..S(LAT+2), index 1 is the youngest
//   en     - operand is actually read this cycle (else sel=0, no hazard)
//   src    - source register address
//   sel    - operand mux address (SEL_RF/SEL_RES/SEL_RES1/SEL_WB)
//   hazard - producer is still inside the execute window, issue must wait
module fpu_hazard_lookup
  import fpu_bypass_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int AW  = AW_DEF
) (
  input  stage_t [LAT+2:1] stages,
  input  logic             en,
  input  logic [AW-1:0]    src,
  output logic [1:0]       sel,
  output logic             hazard
);

  // Walk the stages oldest-to-youngest so that the youngest matching writer is
  // the last one to assign sel/hazard and therefore wins. A writer in S1..S(LAT-1)
  // has no result yet; from S(LAT) on the value sits on one of the bypass
  // paths, and the mux address is simply the distance past S(LAT) plus one.
  always_comb begin
    sel    = SEL_RF;
    hazard = 1'b0;
    for (int i = LAT + 2; i >= 1; i--) begin
      if (en && stages[i].valid && stages[i].wen && (stages[i].fd == src)) begin
        if (i < LAT) begin
          hazard = 1'b1;
          sel    = SEL_RF;
        end else begin
          hazard = 1'b0;
          sel    = 2'(i - LAT + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fpu_bypass_ctrl.sv
// fpu_bypass_ctrl
// Operand-bypass and RAW-hazard controller for a fixed-latency FP execute unit.
// Drives the address inputs of the fs/ft 4:1 operand muxes, stalls issue while
// a producer is still inside the execute window, and emits the regfile
// writeback strobe from the last scoreboard stage.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   issue_valid / issue_ready    - decode handshake (ready is combinational)
//   issue_wen, issue_fd          - destination of the presented op
//   issue_fs, issue_ft           - sources; issue_use_ft qualifies ft
//   flush                        - kill every op that has not reached writeback
//   fs_sel, ft_sel               - operand mux addresses
//   wb_wen, wb_addr              - registered regfile write port controls
// Optional build macro FPU_BYPASS_STATS_EN adds stall_cnt / fwd_cnt counters.
module fpu_bypass_ctrl
  import fpu_bypass_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          issue_wen,
  input  logic [AW-1:0] issue_fd,
  input  logic [AW-1:0] issue_fs,
  input  logic [AW-1:0] issue_ft,
  input  logic          issue_use_ft,
  input  logic          flush,
  output logic [1:0]    fs_sel,
  output logic [1:0]    ft_sel,
  output logic          wb_wen,
  output logic [AW-1:0] wb_addr
`ifdef FPU_BYPASS_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fwd_cnt
`endif
);

  stage_t [LAT+2:1] pipe;
  stage_t [LAT+2:1] pipe_nxt;
  logic             haz_s;
  logic             haz_t;
  logic             accept;

  fpu_hazard_lookup #(.LAT(LAT), .AW(AW)) u_lookup_fs (
    .stages (pipe),
    .en     (issue_valid),
    .src    (issue_fs),
    .sel    (fs_sel),
    .hazard (haz_s)
  );

  fpu_hazard_lookup #(.LAT(LAT), .AW(AW)) u_lookup_ft (
    .stages (pipe),
    .en     (issue_valid & issue_use_ft),
    .src    (issue_ft),
    .sel    (ft_sel),
    .hazard (haz_t)
  );

  assign issue_ready = ~haz_s & ~haz_t & ~flush;
  assign accept      = issue_valid & issue_ready;

  // Next scoreboard contents: the pipe always advances, inserting either the
  // accepted op or a bubble at S1. A flush kills everything that would land in
  // S1..S(LAT+1); the op leaving S(LAT+1) still moves into the writeback stage
  // because its result already exists and is being committed.
  always_comb begin
    pipe_nxt          = '0;
    pipe_nxt[1].valid = accept;
    pipe_nxt[1].wen   = issue_wen;
    pipe_nxt[1].fd    = issue_fd;
    for (int i = 2; i <= LAT + 2; i++) begin
      pipe_nxt[i] = pipe[i-1];
    end
    if (flush) begin
      for (int i = 1; i <= LAT + 1; i++) begin
        pipe_nxt[i].valid = 1'b0;
      end
    end
  end

  // Scoreboard state plus dedicated writeback flops loaded with the value the
  // last stage is about to take, so wb_wen/wb_addr come straight off registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe    <= '0;
      wb_wen  <= 1'b0;
      wb_addr <= '0;
    end else begin
      pipe    <= pipe_nxt;
      wb_wen  <= pipe_nxt[LAT+2].valid & pipe_nxt[LAT+2].wen;
      wb_addr <= pipe_nxt[LAT+2].fd;
    end
  end

`ifdef FPU_BYPASS_STATS_EN
  // Stall counter ignores flush cycles (those are not hazard stalls) and
  // saturates. The forward counter tracks accepted ops that used any bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (issue_valid && !issue_ready && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (accept && ((fs_sel != SEL_RF) || (ft_sel != SEL_RF))) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
